// File: rtl/cache_pkg.sv
// Shared types for the cache refill front-end: command encoding, refill FSM states,
// and word/line containers sized for the default cache geometry.
package cache_pkg;

   localparam int WORD_SIZE_BYTES        = 4;
   localparam int CACHE_BLOCK_SIZE_WORDS = 8;

   typedef enum logic [1:0] {
      CMD_NONE  = 2'b00,
      CMD_WRITE = 2'b01,
      CMD_READ  = 2'b10
   } cache_cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_MEM_REQ,
      ST_MEM_RECV,
      ST_FILL,
      ST_RESP
   } refill_state_e;

   typedef logic [WORD_SIZE_BYTES*8-1:0]                        cache_word_t;
   typedef logic [WORD_SIZE_BYTES*8*CACHE_BLOCK_SIZE_WORDS-1:0] cache_line_t;

endpackage

// File: rtl/line_assembler.sv
// Collects memory beats into a cache line, lowest word first; last_beat_o flags
// the beat that completes the line.
module line_assembler #(
   parameter int Word_Width = 32,
   parameter int Words      = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        clear_i,
   input  logic                        beat_valid_i,
   input  logic [Word_Width-1:0]       beat_data_i,
   output logic [Word_Width*Words-1:0] line_o,
   output logic                        last_beat_o
);

   localparam int Cnt_W = $clog2(Words);
   localparam logic [Cnt_W-1:0] Last_Idx = Cnt_W'(Words - 1);

   logic [Cnt_W-1:0]            beat_cnt_q;
   logic [Word_Width*Words-1:0] line_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         beat_cnt_q <= '0;
         line_q     <= '0;
      end else if (clear_i) begin
         beat_cnt_q <= '0;
      end else if (beat_valid_i) begin
         line_q[beat_cnt_q*Word_Width +: Word_Width] <= beat_data_i;
         beat_cnt_q                                  <= beat_cnt_q + 1'b1;
      end
   end

   assign line_o      = line_q;
   assign last_beat_o = beat_valid_i && (beat_cnt_q == Last_Idx);

endmodule

// File: rtl/cache_refill_ctrl.sv
// Load front-end for the cache: lookup, line refill from memory on a miss, install, respond.
// Define CACHE_REFILL_PERF_CNT_EN to add hit/miss/eviction counters.
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int Addr_Width             = 32,
   parameter int Word_Size_Bytes        = WORD_SIZE_BYTES,
   parameter int Cache_Block_Size_Words = CACHE_BLOCK_SIZE_WORDS,
   parameter int Command_Width          = 2,
   parameter int Line_Width             = Word_Size_Bytes*Cache_Block_Size_Words*8
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic [Addr_Width-1:0]        req_addr_i,
   output logic                         resp_valid_o,
   input  logic                         resp_ready_i,
   output logic [Word_Size_Bytes*8-1:0] resp_data_o,
   output logic [Addr_Width-1:0]        cache_addr_o,
   output logic [Command_Width-1:0]     cache_command_o,
   output logic [Line_Width-1:0]        cache_data_o,
   input  logic                         cache_hit_i,
   input  logic [Word_Size_Bytes*8-1:0] cache_data_i,
   input  logic                         cache_eviction_i,
   input  logic [Addr_Width-1:0]        cache_eviction_addr_i,
   output logic                         mem_req_valid_o,
   input  logic                         mem_req_ready_i,
   output logic [Addr_Width-1:0]        mem_req_addr_o,
   input  logic                         mem_rsp_valid_i,
   input  logic [Word_Size_Bytes*8-1:0] mem_rsp_data_i,
   output logic                         evict_valid_o,
   output logic [Addr_Width-1:0]        evict_addr_o
`ifdef CACHE_REFILL_PERF_CNT_EN
   ,
   output logic [31:0]                  hit_cnt_o,
   output logic [31:0]                  miss_cnt_o,
   output logic [31:0]                  evict_cnt_o
`endif
);

   localparam int Word_Width = Word_Size_Bytes*8;
   localparam int Byte_Off_W = $clog2(Word_Size_Bytes);
   localparam int Idx_W      = $clog2(Cache_Block_Size_Words);
   localparam int Line_Off_W = Byte_Off_W + Idx_W;

   refill_state_e          state_q, state_d;
   cache_cmd_e             cmd;
   logic [Addr_Width-1:0]  addr_q;
   logic [Idx_W-1:0]       word_idx;
   logic [Line_Width-1:0]  line_buf;
   logic                   beat_valid, cnt_clear, last_beat, fill_evict;

   assign word_idx   = addr_q[Byte_Off_W +: Idx_W];
   assign beat_valid = (state_q == ST_MEM_RECV) && mem_rsp_valid_i;
   assign cnt_clear  = (state_q == ST_MEM_REQ) && mem_req_ready_i;
   assign fill_evict = (state_q == ST_FILL) && cache_eviction_i;

   line_assembler #(
      .Word_Width (Word_Width),
      .Words      (Cache_Block_Size_Words)
   ) u_line_assembler (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (cnt_clear),
      .beat_valid_i (beat_valid),
      .beat_data_i  (mem_rsp_data_i),
      .line_o       (line_buf),
      .last_beat_o  (last_beat)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         resp_data_o   <= '0;
         evict_valid_o <= 1'b0;
         evict_addr_o  <= '0;
      end else begin
         state_q       <= state_d;
         evict_valid_o <= fill_evict;
         if (state_q == ST_IDLE && req_valid_i) addr_q <= req_addr_i;
         if (state_q == ST_LOOKUP && cache_hit_i) resp_data_o <= cache_data_i;
         if (state_q == ST_FILL) resp_data_o <= line_buf[word_idx*Word_Width +: Word_Width];
         if (fill_evict) evict_addr_o <= cache_eviction_addr_i;
      end
   end

   // Cache-side and memory-side buses are zero whenever their state is not active.
   always_comb begin
      state_d         = state_q;
      cmd             = CMD_NONE;
      req_ready_o     = 1'b0;
      resp_valid_o    = 1'b0;
      cache_addr_o    = '0;
      cache_data_o    = '0;
      mem_req_valid_o = 1'b0;
      mem_req_addr_o  = '0;
      case (state_q)
         ST_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) state_d = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            cmd          = CMD_READ;
            cache_addr_o = addr_q;
            state_d      = cache_hit_i ? ST_RESP : ST_MEM_REQ;
         end
         ST_MEM_REQ: begin
            mem_req_valid_o = 1'b1;
            mem_req_addr_o  = {addr_q[Addr_Width-1:Line_Off_W], {Line_Off_W{1'b0}}};
            if (mem_req_ready_i) state_d = ST_MEM_RECV;
         end
         ST_MEM_RECV: begin
            if (last_beat) state_d = ST_FILL;
         end
         ST_FILL: begin
            cmd          = CMD_WRITE;
            cache_addr_o = addr_q;
            cache_data_o = line_buf;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cache_command_o = Command_Width'(cmd);

`ifdef CACHE_REFILL_PERF_CNT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hit_cnt_o   <= '0;
         miss_cnt_o  <= '0;
         evict_cnt_o <= '0;
      end else begin
         if (state_q == ST_LOOKUP && cache_hit_i)  hit_cnt_o  <= hit_cnt_o + 32'd1;
         if (state_q == ST_LOOKUP && !cache_hit_i) miss_cnt_o <= miss_cnt_o + 32'd1;
         if (fill_evict)                           evict_cnt_o <= evict_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed hit/miss/eviction/backpressure/reset
// steps followed by randomized transactions, compared against a line/offset arithmetic model.
module tb_cache_refill_ctrl;
   import cache_pkg::*;

   localparam int LINE_BYTES = WORD_SIZE_BYTES * CACHE_BLOCK_SIZE_WORDS;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              req_valid_i, req_ready_o;
   logic [31:0]       req_addr_i;
   logic              resp_valid_o, resp_ready_i;
   cache_word_t       resp_data_o;
   logic [31:0]       cache_addr_o;
   logic [1:0]        cache_command_o;
   cache_line_t       cache_data_o;
   logic              cache_hit_i;
   cache_word_t       cache_data_i;
   logic              cache_eviction_i;
   logic [31:0]       cache_eviction_addr_i;
   logic              mem_req_valid_o, mem_req_ready_i;
   logic [31:0]       mem_req_addr_o;
   logic              mem_rsp_valid_i;
   cache_word_t       mem_rsp_data_i;
   logic              evict_valid_o;
   logic [31:0]       evict_addr_o;

   int checks = 0;
   int errors = 0;
   cache_word_t beats [CACHE_BLOCK_SIZE_WORDS];

   cache_refill_ctrl dut (
      .clk_i                 (clk_i),
      .rst_ni                (rst_ni),
      .req_valid_i           (req_valid_i),
      .req_ready_o           (req_ready_o),
      .req_addr_i            (req_addr_i),
      .resp_valid_o          (resp_valid_o),
      .resp_ready_i          (resp_ready_i),
      .resp_data_o           (resp_data_o),
      .cache_addr_o          (cache_addr_o),
      .cache_command_o       (cache_command_o),
      .cache_data_o          (cache_data_o),
      .cache_hit_i           (cache_hit_i),
      .cache_data_i          (cache_data_i),
      .cache_eviction_i      (cache_eviction_i),
      .cache_eviction_addr_i (cache_eviction_addr_i),
      .mem_req_valid_o       (mem_req_valid_o),
      .mem_req_ready_i       (mem_req_ready_i),
      .mem_req_addr_o        (mem_req_addr_o),
      .mem_rsp_valid_i       (mem_rsp_valid_i),
      .mem_rsp_data_i        (mem_rsp_data_i),
      .evict_valid_o         (evict_valid_o),
      .evict_addr_o          (evict_addr_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain address arithmetic on the line geometry.
   function automatic logic [31:0] lineBase(input logic [31:0] a);
      return a - (a % LINE_BYTES);
   endfunction

   function automatic int wordIndex(input logic [31:0] a);
      return int'((a / WORD_SIZE_BYTES) % CACHE_BLOCK_SIZE_WORDS);
   endfunction

   function automatic cache_line_t expectedLine();
      cache_line_t l = '0;
      for (int i = 0; i < CACHE_BLOCK_SIZE_WORDS; i++) l = l | (cache_line_t'(beats[i]) << (32 * i));
      return l;
   endfunction

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_req_ready"}, req_ready_o, 1);
      checkOutput({tag, "_cmd"}, cache_command_o, 0);
      checkOutput({tag, "_resp_valid"}, resp_valid_o, 0);
      checkOutput({tag, "_mem_req"}, mem_req_valid_o, 0);
      checkOutput({tag, "_evict"}, evict_valid_o, 0);
      checkOutput({tag, "_cache_addr"}, cache_addr_o, 0);
      checkOutput({tag, "_cache_data"}, cache_data_o, 0);
   endtask

   // One full transaction starting and ending at a negedge with the DUT idle.
   task automatic applyStimulus(input logic [31:0] addr, input bit hit, input cache_word_t hit_word,
                                input bit evict, input logic [31:0] ev_addr,
                                input int req_wait, input int max_gap, input int resp_wait);
      cache_word_t exp_resp;
      checkOutput("idle_ready", req_ready_o, 1);
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      req_addr_i  = $urandom;
      checkOutput("lookup_cmd", cache_command_o, 2'b10);
      checkOutput("lookup_addr", cache_addr_o, addr);
      checkOutput("lookup_busy", req_ready_o, 0);
      cache_hit_i  = hit;
      cache_data_i = hit ? hit_word : cache_word_t'($urandom);
      @(negedge clk_i);
      cache_hit_i  = 1'b0;
      cache_data_i = $urandom;
      if (hit) begin
         exp_resp = hit_word;
         checkOutput("hit_no_mem", mem_req_valid_o, 0);
      end else begin
         for (int w = 0; w < req_wait; w++) begin
            checkOutput("memreq_hold_valid", mem_req_valid_o, 1);
            checkOutput("memreq_hold_addr", mem_req_addr_o, lineBase(addr));
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = $urandom;
            @(negedge clk_i);
         end
         checkOutput("memreq_valid", mem_req_valid_o, 1);
         checkOutput("memreq_addr", mem_req_addr_o, lineBase(addr));
         mem_rsp_valid_i = 1'b0;
         mem_req_ready_i = 1'b1;
         @(negedge clk_i);
         mem_req_ready_i = 1'b0;
         checkOutput("recv_req_dropped", mem_req_valid_o, 0);
         for (int i = 0; i < CACHE_BLOCK_SIZE_WORDS; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
               mem_rsp_valid_i = 1'b0;
               mem_rsp_data_i  = $urandom;
               @(negedge clk_i);
            end
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = beats[i];
            @(negedge clk_i);
         end
         mem_rsp_valid_i = 1'b0;
         checkOutput("fill_cmd", cache_command_o, 2'b01);
         checkOutput("fill_addr", cache_addr_o, addr);
         checkOutput("fill_line", cache_data_o, expectedLine());
         cache_eviction_i      = evict;
         cache_eviction_addr_i = ev_addr;
         @(negedge clk_i);
         cache_eviction_i      = 1'b0;
         cache_eviction_addr_i = $urandom;
         checkOutput("evict_pulse", evict_valid_o, evict);
         if (evict) checkOutput("evict_addr", evict_addr_o, ev_addr);
         exp_resp = beats[wordIndex(addr)];
      end
      for (int r = 0; r < resp_wait; r++) begin
         checkOutput("resp_hold_valid", resp_valid_o, 1);
         checkOutput("resp_hold_data", resp_data_o, exp_resp);
         checkOutput("resp_cmd_idle", cache_command_o, 0);
         @(negedge clk_i);
      end
      checkOutput("resp_valid", resp_valid_o, 1);
      checkOutput("resp_data", resp_data_o, exp_resp);
      resp_ready_i = 1'b1;
      @(negedge clk_i);
      resp_ready_i = 1'b0;
      checkOutput("done_resp_low", resp_valid_o, 0);
      checkOutput("done_evict_low", evict_valid_o, 0);
      checkOutput("done_ready", req_ready_o, 1);
   endtask

   initial begin
      rst_ni = 1'b0;
      req_valid_i = 1'b0; req_addr_i = '0; resp_ready_i = 1'b0;
      cache_hit_i = 1'b0; cache_data_i = '0; cache_eviction_i = 1'b0; cache_eviction_addr_i = '0;
      mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      checkResetOutputs("post_reset");

      // Asynchronous reset asserted mid-cycle while in LOOKUP
      req_valid_i = 1'b1;
      req_addr_i  = 32'h0000_0040;
      @(posedge clk_i);
      #2 rst_ni = 1'b0;
      #1 checkResetOutputs("async_reset");
      req_valid_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      $display("[TB] hit");
      applyStimulus(32'h0000_0044, 1'b1, 32'hDEAD_BEEF, 1'b0, '0, 0, 0, 0);

      $display("[TB] miss");
      for (int i = 0; i < CACHE_BLOCK_SIZE_WORDS; i++) beats[i] = 32'h10 + i;
      applyStimulus(32'h0000_0104, 1'b0, '0, 1'b0, '0, 0, 0, 0);

      $display("[TB] miss with eviction");
      for (int i = 0; i < CACHE_BLOCK_SIZE_WORDS; i++) beats[i] = 32'hA0 + i;
      applyStimulus(32'h0000_031C, 1'b0, '0, 1'b1, 32'h0000_2100, 0, 0, 0);

      $display("[TB] backpressure");
      for (int i = 0; i < CACHE_BLOCK_SIZE_WORDS; i++) beats[i] = $urandom;
      applyStimulus(32'h0000_0F48, 1'b0, '0, 1'b0, '0, 5, 3, 3);

      $display("[TB] reset mid-miss");
      req_valid_i = 1'b1;
      req_addr_i  = 32'h0000_0208;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      @(negedge clk_i);
      mem_req_ready_i = 1'b1;
      @(negedge clk_i);
      mem_req_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_rsp_valid_i = 1'b1;
         mem_rsp_data_i  = 32'h5000 + i;
         @(negedge clk_i);
      end
      mem_rsp_valid_i = 1'b0;
      rst_ni = 1'b0;
      #1 checkResetOutputs("midmiss_reset");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         checkOutput("midmiss_no_write", cache_command_o, 0);
      end
      rst_ni = 1'b1;
      @(negedge clk_i);
      applyStimulus(32'h0000_0208, 1'b1, 32'h1234_5678, 1'b0, '0, 0, 0, 0);
      for (int i = 0; i < CACHE_BLOCK_SIZE_WORDS; i++) beats[i] = 32'h700 + i;
      applyStimulus(32'h0000_021C, 1'b0, '0, 1'b0, '0, 1, 0, 0);

      $display("[TB] randomized transactions");
      for (int t = 0; t < 16; t++) begin
         for (int i = 0; i < CACHE_BLOCK_SIZE_WORDS; i++) beats[i] = $urandom;
         applyStimulus($urandom, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                       $urandom, $urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Sequential front-end controller for the combinational cache block: accepts one load request at a time from the core and performs the cache lookup.
- On a miss, fetches the full line from memory one word per beat and assembles it. It then installs the line in the cache with a write command and returns the requested word to the core.
- Reports any eviction the cache signals during installation.

Parameters:
- Addr_Width, 32, byte address width.
- Word_Size_Bytes, 4, bytes per word.
- Cache_Block_Size_Words, 8, words per line. Power of two, ≥2.
- Command_Width, 2, cache command width: 00 idle, 01 write, 10 read.
- Line_Width, Word_Size_Bytes*Cache_Block_Size_Words*8, line width in bits.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- req_valid_i  input  1  core load request valid
- req_ready_o  output  1  controller can accept a request
- req_addr_i  input  Addr_Width  request address (word index in low bits, as the cache decodes it)
- resp_valid_o  output  1  response word valid
- resp_ready_i  input  1  core accepts response
- resp_data_o  output  Word_Size_Bytes*8  returned word
- cache_addr_o  output  Addr_Width  address to cache
- cache_command_o  output  Command_Width  command to cache
- cache_data_o  output  Line_Width  line to install
- cache_hit_i  input  1  cache hit
- cache_data_i  input  Word_Size_Bytes*8  cache read word
- cache_eviction_i  input  1  cache evicted a line
- cache_eviction_addr_i  input  Addr_Width  evicted line address
- mem_req_valid_o  output  1  memory line-read request
- mem_req_ready_i  input  1  memory accepts request
- mem_req_addr_o  output  Addr_Width  line-aligned address (offset bits zero)
- mem_rsp_valid_i  input  1  memory beat valid
- mem_rsp_data_i  input  Word_Size_Bytes*8  memory beat, words in ascending order
- evict_valid_o  output  1  one-cycle eviction pulse
- evict_addr_o  output  Addr_Width  evicted line address

Behaviour:
- Clock and reset: single clock clk_i. rst_ni is asynchronous and active-low.
- Reset values:
  - State returns to IDLE.
  - All outputs are 0, except req_ready_o, which is 1.
  - Beat counter, line buffer and address register are cleared.
- States: IDLE, LOOKUP, MEM_REQ, MEM_RECV, FILL, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, register the address and go to LOOKUP.
  - req_ready_o=0 in every other state.
- LOOKUP (1 cycle):
  - Drive cache_command_o=10 and cache_addr_o=registered address.
  - On cache_hit_i, capture cache_data_i and go to RESP.
  - Otherwise go to MEM_REQ.
- MEM_REQ:
  - mem_req_valid_o=1 and mem_req_addr_o=line-aligned address.
  - Hold both until mem_req_ready_i, then clear the beat counter and go to MEM_RECV.
- MEM_RECV:
  - Each mem_rsp_valid_i beat writes word lane[counter] and increments the counter.
  - After beat Cache_Block_Size_Words-1, go to FILL.
  - Beats arriving in other states are ignored.
- FILL (exactly 1 cycle):
  - Drive cache_command_o=01, cache_addr_o=registered address, cache_data_o=line buffer.
  - If cache_eviction_i, register evict_valid_o=1 for the next cycle only, with evict_addr_o=cache_eviction_addr_i.
  - Capture line buffer word [offset] as the response, then go to RESP.
- RESP:
  - resp_valid_o=1 and resp_data_o stay stable until resp_ready_i, then go to IDLE.
- Command outside LOOKUP and FILL: cache_command_o=00.
- Latency, measured from the cycle the request is accepted:
  - Hit: resp_valid_o asserts 2 cycles later.
  - Miss: 2 + handshake wait + N beats + 1 cycles.
- resp_ready_i held high: back-to-back requests are possible, one accepted every 3 cycles on hits.
- Reset mid-miss: the line is discarded, no cache write is issued, and the next request restarts cleanly.

Optional Feature:
- Macro: CACHE_REFILL_PERF_CNT_EN.
- When defined:
  - Adds outputs hit_cnt_o, miss_cnt_o and evict_cnt_o, each 32 bits.
  - hit_cnt_o increments on a LOOKUP hit.
  - miss_cnt_o increments on a LOOKUP miss.
  - evict_cnt_o increments on a FILL eviction.
  - Counters wrap at 2^32 and are cleared by reset.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cache_pkg holds:
  - cache command enum (CMD_NONE=00, CMD_WRITE=01, CMD_READ=10);
  - refill state enum;
  - cache_word_t;
  - cache_line_t.
- Sub-module line_assembler: beat counter plus line buffer, with a last_beat_o strobe.

Test Plan:
1. Reset with rst_ni low mid-cycle → all outputs at reset values immediately and req_ready_o=1.
2. Hit: addr 0x0000_0044, cache_hit_i=1, cache_data_i=0xDEAD_BEEF → read command at cycle 1, resp 0xDEADBEEF at cycle 2, no mem request.
3. Miss: addr 0x0000_0104 with beats 0x10..0x17 → mem_req_addr_o=0x0000_0100, FILL writes line {0x17..0x10}, resp_data_o=0x11.
4. Miss with eviction: cache_eviction_i=1, evict addr 0x0000_2100 during FILL → evict_valid_o is a single pulse carrying 0x0000_2100.
5. Backpressure: mem_req_ready_i low for 5 cycles, mem_rsp_valid_i gapped, resp_ready_i low for 3 cycles → request and address held stable, beats counted correctly, response held stable.
6. Reset asserted after beat 3 of a miss → no write command issued; the next request, a hit, completes normally.
